// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the rvseed instruction-fetch sequencer.
// Provides CPU_WIDTH (default 32), the reset PC and the FSM state encoding.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

package fetch_ctrl_pkg;

    localparam int unsigned XLEN = `CPU_WIDTH;

    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_KILL = 2'd2,
        FETCH_WAIT = 2'd3
    } fetch_state_e;

    // Sequential PC; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch bus bundle: imem req/ack transaction plus the decode valid/ready link.
// master = fetch sequencer, slave = memory/decode side.
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, inst_ready
    );

endinterface

// File: rtl/fetch_perf_cnt.sv
// Fetch performance counters: delivered instructions and discarded acks.
// Both counters are 32-bit and wrap.
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        handoff,
    input  logic        kill_ack,
    output logic [31:0] fetch_cnt,
    output logic [31:0] kill_cnt
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] kill_cnt_q, kill_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        kill_cnt_d  = kill_cnt_q;
        if (handoff)  fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (kill_ack) kill_cnt_d  = kill_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            kill_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            kill_cnt_q  <= kill_cnt_d;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign kill_cnt  = kill_cnt_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs imem req/ack, feeds decode.
// Define FETCH_PERF_CNT_EN to add the fetch_cnt/kill_cnt performance counters.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     kill_cnt,
`endif
    fetch_ctrl_if.master    bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            valid_q, valid_d;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        unique case (state_q)
            FETCH_IDLE: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (ena) begin
                    state_d = FETCH_REQ;
                    addr_d  = redirect_valid ? redirect_pc : pc_q;
                end
            end
            FETCH_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (!bus.imem_ack) begin
                        state_d = FETCH_KILL;
                    end else if (ena) begin
                        addr_d = redirect_pc;
                    end else begin
                        state_d = FETCH_IDLE;
                    end
                end else if (bus.imem_ack) begin
                    inst_d    = bus.imem_rdata;
                    inst_pc_d = addr_q;
                    valid_d   = 1'b1;
                    pc_d      = seq_pc(addr_q);
                    state_d   = FETCH_WAIT;
                end
            end
            FETCH_KILL: begin
                // A redirect coinciding with the ack still wins.
                if (redirect_valid) pc_d = redirect_pc;
                if (bus.imem_ack) begin
                    if (ena) begin
                        state_d = FETCH_REQ;
                        addr_d  = redirect_valid ? redirect_pc : pc_q;
                    end else begin
                        state_d = FETCH_IDLE;
                    end
                end
            end
            FETCH_WAIT: begin
                if (redirect_valid || bus.inst_ready) begin
                    valid_d = 1'b0;
                    if (redirect_valid) pc_d = redirect_pc;
                    if (ena) begin
                        state_d = FETCH_REQ;
                        addr_d  = redirect_valid ? redirect_pc : pc_q;
                    end else begin
                        state_d = FETCH_IDLE;
                    end
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH_IDLE;
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.imem_req   = (state_q == FETCH_REQ) || (state_q == FETCH_KILL);
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic handoff;
    logic kill_ack;

    assign handoff  = valid_q && bus.inst_ready && !redirect_valid;
    assign kill_ack = bus.imem_ack &&
                      ((state_q == FETCH_KILL) ||
                       ((state_q == FETCH_REQ) && redirect_valid));

    fetch_perf_cnt u_perf (
        .clk       (clk),
        .rst       (rst),
        .handoff   (handoff),
        .kill_ack  (kill_ack),
        .fetch_cnt (fetch_cnt),
        .kill_cnt  (kill_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with hand-computed expectations.
// Counter checks are active when FETCH_PERF_CNT_EN is defined.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    int          vectors = 0;
    int          miscompares = 0;

    fetch_ctrl_if bus();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] kill_cnt;
`endif

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt      (fetch_cnt),
        .kill_cnt       (kill_cnt),
`endif
        .bus            (bus.master)
    );

    always #5 clk = ~clk;

    // Zero-latency memory image: data is the address scrambled by K.
    assign bus.imem_rdata = bus.imem_addr ^ K;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        ena            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.imem_ack   = 1'b0;
        bus.inst_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        check("rst_pc_q", dut.pc_q, 32'd0);
        step();
        check("idle_no_ena", 32'(bus.imem_req), 32'd0);

        // Zero-wait streaming, one instruction every two cycles.
        ena            = 1'b1;
        bus.imem_ack   = 1'b1;
        bus.inst_ready = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            check("seq_req", 32'(bus.imem_req), 32'd1);
            check("seq_addr", bus.imem_addr, 32'(4 * i));
            step();
            check("seq_valid", 32'(bus.inst_valid), 32'd1);
            check("seq_inst_pc", bus.inst_pc, 32'(4 * i));
            check("seq_inst", bus.inst, 32'(4 * i) ^ K);
            check("seq_req_low", 32'(bus.imem_req), 32'd0);
            if (i < 3) step();
        end

        // Decode stall: outputs hold, no new request.
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 32'(bus.inst_valid), 32'd1);
            check("stall_inst_pc", bus.inst_pc, 32'hC);
            check("stall_inst", bus.inst, 32'hC ^ K);
            check("stall_req", 32'(bus.imem_req), 32'd0);
        end
        bus.inst_ready = 1'b1;
        bus.imem_ack   = 1'b0;
        step();
        check("stall_rel_req", 32'(bus.imem_req), 32'd1);
        check("stall_rel_addr", bus.imem_addr, 32'h10);
        check("stall_rel_valid", 32'(bus.inst_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt_4", fetch_cnt, 32'd4);
`endif

        // Slow ack with redirect while the request is outstanding.
        step();
        check("slow_addr1", bus.imem_addr, 32'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("kill_req", 32'(bus.imem_req), 32'd1);
        check("kill_addr", bus.imem_addr, 32'h10);
        check("kill_pc_q", dut.pc_q, 32'h100);
        step();
        check("kill_addr2", bus.imem_addr, 32'h10);
        bus.imem_ack = 1'b1;
        step();
        check("kill_done_valid", 32'(bus.inst_valid), 32'd0);
        check("kill_done_req", 32'(bus.imem_req), 32'd1);
        check("kill_done_addr", bus.imem_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
        check("kill_cnt_1", kill_cnt, 32'd1);
`endif
        step();
        check("tgt_inst_pc", bus.inst_pc, 32'h100);
        check("tgt_inst", bus.inst, 32'h100 ^ K);
        step();
        check("tgt_next_addr", bus.imem_addr, 32'h104);

        // Redirect coincident with ack: data dropped, retarget at once.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("ackred_valid", 32'(bus.inst_valid), 32'd0);
        check("ackred_req", 32'(bus.imem_req), 32'd1);
        check("ackred_addr", bus.imem_addr, 32'h200);
`ifdef FETCH_PERF_CNT_EN
        check("kill_cnt_2", kill_cnt, 32'd2);
        check("fetch_cnt_5", fetch_cnt, 32'd5);
`endif
        step();
        check("ackred_inst_pc", bus.inst_pc, 32'h200);
        check("ackred_inst", bus.inst, 32'h200 ^ K);

        // Redirect in WAIT with ready high voids the handoff.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        redirect_valid = 1'b0;
        check("flush_valid", 32'(bus.inst_valid), 32'd0);
        check("flush_addr", bus.imem_addr, 32'h40);
`ifdef FETCH_PERF_CNT_EN
        check("flush_fetch_cnt", fetch_cnt, 32'd5);
`endif
        step();
        check("flush_inst_pc", bus.inst_pc, 32'h40);

        // Wrap at the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
        check("wrap_inst", bus.inst, 32'h5A5A_5A59);
        step();
        check("wrap_next_addr", bus.imem_addr, 32'h0);
        check("wrap_next_req", 32'(bus.imem_req), 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_cnt_6", fetch_cnt, 32'd6);
`endif
        step();
        step();
        check("pre_rst_addr", bus.imem_addr, 32'h4);
        bus.imem_ack = 1'b0;
        step();
        check("pre_rst_req", 32'(bus.imem_req), 32'd1);
        check("pre_rst_pc_q", dut.pc_q, 32'h4);

        // Asynchronous reset mid-request.
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", 32'(bus.imem_req), 32'd0);
        check("arst_pc_q", dut.pc_q, 32'd0);
        check("arst_addr", bus.imem_addr, 32'd0);
        check("arst_valid", 32'(bus.inst_valid), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("arst_fetch_cnt", fetch_cnt, 32'd0);
`endif
        ena = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("off_req", 32'(bus.imem_req), 32'd0);

        // IDLE redirect used in the same cycle as ena.
        ena            = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        check("idle_red_addr", bus.imem_addr, 32'h300);

        // ena low does not abort the outstanding fetch.
        ena          = 1'b0;
        bus.imem_ack = 1'b1;
        step();
        check("ena_off_valid", 32'(bus.inst_valid), 32'd1);
        check("ena_off_inst_pc", bus.inst_pc, 32'h300);
        step();
        check("ena_off_idle", 32'(bus.imem_req), 32'd0);
        check("ena_off_clr", 32'(bus.inst_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
